// File: rtl/fsm1_pkg.sv
// fsm1_pkg: phase codes shared by the FSM1 controller and its monitor,
// plus the monitor-state encoding and the legal-transition rule.
// Importing this package on both sides keeps the code values in lockstep.
package fsm1_pkg;

  // Controller output code {o1,o2,err} for each phase.
  localparam logic [2:0] CODE_IDLE = 3'b000;
  localparam logic [2:0] CODE_S1   = 3'b100;
  localparam logic [2:0] CODE_S2   = 3'b010;
  localparam logic [2:0] CODE_ER   = 3'b111;

  typedef enum logic [1:0] {
    M_IDLE = 2'd0,
    M_S1   = 2'd1,
    M_S2   = 2'd2,
    M_ER   = 2'd3
  } mstate_t;

  // True when prev -> cur is a move the controller is allowed to make.
  function automatic logic trans_ok(mstate_t prev, mstate_t cur);
    logic ok;
    ok = 1'b0;
    case (prev)
      M_IDLE:  ok = (cur != M_S2);
      M_S1:    ok = (cur != M_IDLE);
      M_S2:    ok = (cur != M_S1);
      M_ER:    ok = (cur == M_ER) || (cur == M_IDLE);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/fsm1_seq_monitor_sat_counter.sv
// sat_counter: W-bit up counter that sticks at all-ones instead of wrapping.
// Ports: clk, rst (async active-high), clr (sync clear, wins over inc),
//        inc (count request), cnt (registered count), at_max (cnt is all-ones).
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         at_max
);

  assign at_max = &cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !at_max) begin
      cnt <= cnt + {{(W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/fsm1_seq_monitor.sv
// fsm1_seq_monitor: follows the FSM1 controller's {o1,o2,err} code, counts
// completed passes and error entries, raises a sticky alarm at ERR_THRESH
// errors and a sticky viol on illegal codes/transitions. All outputs registered.
// Ports: clk, rst, o1_in/o2_in/err_in (code), clr (sync clear),
//        pass_cnt, err_cnt, pass_pulse, err_alarm, viol.
module fsm1_seq_monitor
  import fsm1_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int ERR_THRESH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             o1_in,
  input  logic             o2_in,
  input  logic             err_in,
  input  logic             clr,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             pass_pulse,
  output logic             err_alarm,
  output logic             viol
);

  localparam logic [CNT_W-1:0] THRESH = CNT_W'(ERR_THRESH);

  mstate_t          state, state_n;
  mstate_t          cur;
  logic [2:0]       code;
  logic             code_ok;
  logic             trans_legal;
  logic             pass_ev, err_ev, viol_ev;
  logic             pass_at_max, err_at_max;
  logic [CNT_W-1:0] err_cnt_inc;

  assign code = {o1_in, o2_in, err_in};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= M_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    cur         = state;
    code_ok     = 1'b1;
    state_n     = state;
    trans_legal = 1'b0;
    pass_ev     = 1'b0;
    err_ev      = 1'b0;
    viol_ev     = 1'b0;

    case (code)
      CODE_IDLE: cur = M_IDLE;
      CODE_S1:   cur = M_S1;
      CODE_S2:   cur = M_S2;
      CODE_ER:   cur = M_ER;
      default:   code_ok = 1'b0;
    endcase

    // Illegal code holds the state; a legal code is always followed, even
    // across an illegal transition, so the monitor resynchronises.
    state_n     = cur;
    trans_legal = code_ok && trans_ok(state, cur);

    // clr drops any event or violation arriving in the same cycle.
    pass_ev = trans_legal && (state == M_S2) && (cur == M_IDLE) && !clr;
    err_ev  = trans_legal && (cur == M_ER) && (state != M_ER) && !clr;
    viol_ev = !trans_legal && !clr;
  end

  sat_counter #(.W(CNT_W)) u_pass_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (clr),
    .inc    (pass_ev && !pass_at_max),
    .cnt    (pass_cnt),
    .at_max (pass_at_max)
  );

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (clr),
    .inc    (err_ev && !err_at_max),
    .cnt    (err_cnt),
    .at_max (err_at_max)
  );

  assign err_cnt_inc = err_cnt + {{(CNT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pass_pulse <= 1'b0;
      err_alarm  <= 1'b0;
      viol       <= 1'b0;
    end else if (clr) begin
      pass_pulse <= 1'b0;
      err_alarm  <= 1'b0;
      viol       <= 1'b0;
    end else begin
      // The pulse follows the event, not the counter, so it keeps firing
      // after pass_cnt has saturated.
      pass_pulse <= pass_ev;
      // Set alongside the increment that makes err_cnt equal THRESH, so the
      // alarm and the new count appear in the same cycle.
      if (err_ev && !err_at_max && (err_cnt_inc == THRESH)) begin
        err_alarm <= 1'b1;
      end
      if (viol_ev) begin
        viol <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fsm1_seq_monitor.sv
module tb_fsm1_seq_monitor;

  typedef struct {
    logic [2:0] code;
    logic       clr;
    logic [7:0] pc;
    logic [7:0] ec;
    logic       pu;
    logic       al;
    logic       vi;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       o1_in, o2_in, err_in, clr;
  logic [7:0] pass_cnt, err_cnt;
  logic       pass_pulse, err_alarm, viol;
  logic [1:0] pass_cnt2, err_cnt2;
  logic       pass_pulse2, err_alarm2, viol2;

  int n_chk  = 0;
  int n_fail = 0;

  vec_t vt[$];

  always #5 clk = ~clk;

  fsm1_seq_monitor #(.CNT_W(8), .ERR_THRESH(4)) dut (
    .clk(clk), .rst(rst), .o1_in(o1_in), .o2_in(o2_in), .err_in(err_in),
    .clr(clr), .pass_cnt(pass_cnt), .err_cnt(err_cnt),
    .pass_pulse(pass_pulse), .err_alarm(err_alarm), .viol(viol)
  );

  fsm1_seq_monitor #(.CNT_W(2), .ERR_THRESH(2)) dut2 (
    .clk(clk), .rst(rst), .o1_in(o1_in), .o2_in(o2_in), .err_in(err_in),
    .clr(clr), .pass_cnt(pass_cnt2), .err_cnt(err_cnt2),
    .pass_pulse(pass_pulse2), .err_alarm(err_alarm2), .viol(viol2)
  );

  function automatic vec_t mk(logic [2:0] code, logic c, logic [7:0] pc,
                              logic [7:0] ec, logic pu, logic al, logic vi);
    vec_t v;
    v.code = code; v.clr = c; v.pc = pc; v.ec = ec;
    v.pu = pu; v.al = al; v.vi = vi;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive a code at the falling edge, let the rising edge sample it, then
  // return just after that edge so outputs reflect the sampled code.
  task automatic step(input logic [2:0] code, input logic c);
    @(negedge clk);
    {o1_in, o2_in, err_in} = code;
    clr = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pulses;
    rst = 1'b1;
    {o1_in, o2_in, err_in} = 3'b000;
    clr = 1'b0;

    // Vector table: {code, clr} -> {pass_cnt, err_cnt, pulse, alarm, viol}
    // one pass
    vt.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk(3'b100, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk(3'b010, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk(3'b000, 0, 1, 0, 1, 0, 0));
    vt.push_back(mk(3'b000, 0, 1, 0, 0, 0, 0));
    vt.push_back(mk(3'b000, 1, 0, 0, 0, 0, 0));
    // four error entries; ER->ER and ER->IDLE add nothing; alarm at 4
    for (int r = 1; r <= 4; r++) begin
      vt.push_back(mk(3'b000, 0, 0, 8'(r-1), 0, 0, 0));
      vt.push_back(mk(3'b100, 0, 0, 8'(r-1), 0, 0, 0));
      vt.push_back(mk(3'b111, 0, 0, 8'(r),   0, (r == 4), 0));
      vt.push_back(mk(3'b111, 0, 0, 8'(r),   0, (r == 4), 0));
      vt.push_back(mk(3'b000, 0, 0, 8'(r),   0, (r == 4), 0));
    end
    // IDLE->S2 violation; resync to S2 so the next 000 is a legal pass
    vt.push_back(mk(3'b000, 1, 0, 0, 0, 0, 0));
    vt.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk(3'b010, 0, 0, 0, 0, 0, 1));
    vt.push_back(mk(3'b000, 0, 1, 0, 1, 0, 1));
    vt.push_back(mk(3'b000, 1, 0, 0, 0, 0, 0));
    // illegal code in S1 holds state; following S2 is legal
    vt.push_back(mk(3'b100, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk(3'b110, 0, 0, 0, 0, 0, 1));
    vt.push_back(mk(3'b010, 0, 0, 0, 0, 0, 1));
    vt.push_back(mk(3'b000, 0, 1, 0, 1, 0, 1));
    vt.push_back(mk(3'b000, 1, 0, 0, 0, 0, 0));
    // ER->S1 illegal, no count; S1->IDLE under clr is dropped
    vt.push_back(mk(3'b111, 0, 0, 1, 0, 0, 0));
    vt.push_back(mk(3'b100, 0, 0, 1, 0, 0, 1));
    vt.push_back(mk(3'b000, 1, 0, 0, 0, 0, 0));

    // reset state
    #12;
    chk("reset_outputs", {13'd0, pass_cnt, err_cnt, pass_pulse, err_alarm, viol}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vt[i]) begin
      step(vt[i].code, vt[i].clr);
      chk($sformatf("vec%0d", i),
          {13'd0, pass_cnt, err_cnt, pass_pulse, err_alarm, viol},
          {13'd0, vt[i].pc, vt[i].ec, vt[i].pu, vt[i].al, vt[i].vi});
    end

    // Saturation on the 2-bit instance: 5 passes, 5 pulses, count stops at 3
    @(negedge clk);
    rst = 1'b1;
    {o1_in, o2_in, err_in} = 3'b000;
    clr = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int p = 0; p < 5; p++) begin
      step(3'b100, 0); if (pass_pulse2) pulses++;
      step(3'b010, 0); if (pass_pulse2) pulses++;
      step(3'b000, 0); if (pass_pulse2) pulses++;
    end
    step(3'b000, 0); if (pass_pulse2) pulses++;
    chk("sat_pass_cnt2", {30'd0, pass_cnt2}, 32'd3);
    chk("sat_pulses2", pulses, 5);
    chk("wide_pass_cnt", {24'd0, pass_cnt}, 32'd5);
    chk("sat_viol2", {31'd0, viol2}, 32'd0);

    // clr in the same cycle as S2->IDLE: counters cleared, no pulse
    step(3'b100, 0);
    step(3'b010, 0);
    step(3'b000, 1);
    chk("clr_pass_cnt2", {30'd0, pass_cnt2}, 32'd0);
    chk("clr_no_pulse", {30'd0, pass_pulse, pass_pulse2}, 32'd0);
    chk("clr_pass_cnt", {24'd0, pass_cnt}, 32'd0);

    // Build err_cnt=2 (alarm on the THRESH=2 instance), stop in S2
    step(3'b000, 0);
    step(3'b111, 0);
    step(3'b000, 0);
    step(3'b111, 0);
    step(3'b000, 0);
    step(3'b100, 0);
    step(3'b010, 0);
    chk("pre_rst_err_cnt", {24'd0, err_cnt}, 32'd2);
    chk("pre_rst_alarm2", {31'd0, err_alarm2}, 32'd1);

    // Async reset mid-cycle while in S2: outputs drop without a clock edge
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_outputs",
        {13'd0, pass_cnt, err_cnt, pass_pulse, err_alarm, viol}, 32'd0);
    chk("async_rst_outputs2",
        {27'd0, pass_cnt2, err_cnt2, err_alarm2}, 32'd0);
    {o1_in, o2_in, err_in} = 3'b111;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_er_count", {24'd0, err_cnt}, 32'd1);
    chk("post_rst_er_viol", {31'd0, viol}, 32'd0);

    // First code S2 after reset is judged from M_IDLE: violation
    @(negedge clk);
    rst = 1'b1;
    {o1_in, o2_in, err_in} = 3'b010;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_s2_viol", {31'd0, viol}, 32'd1);
    chk("post_rst_s2_nocount", {16'd0, pass_cnt, err_cnt}, 32'd0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/fsm1_seq_monitor.md
# fsm1_seq_monitor

Downstream observer for the three-phase handshake controller (FSM1). Samples the controller's registered `{o1,o2,err}` code each cycle and reconstructs its phase. Counts completed passes (IDLE→S1→S2→IDLE) and error entries, raises a sticky alarm at an error threshold, and flags illegal codes or transitions. Sits between the controller and the status/interrupt register block in the same clock domain.

## Interface
- `CNT_W`, 8: width of both event counters; legal range ≥2.
- `ERR_THRESH`, 4: error count at which `err_alarm` sets; legal range 1 … 2^CNT_W−1.
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `o1_in`  in  1  controller `o1`, registered upstream, same clock.
- `o2_in`  in  1  controller `o2`, registered upstream, same clock.
- `err_in`  in  1  controller `err`, registered upstream, same clock.
- `clr`  in  1  synchronous clear of counters and sticky flags.
- `pass_cnt`  out  CNT_W  saturating count of completed passes.
- `err_cnt`  out  CNT_W  saturating count of entries into ER.
- `pass_pulse`  out  1  one-cycle strobe per completed pass.
- `err_alarm`  out  1  sticky; set when `err_cnt` reaches `ERR_THRESH`.
- `viol`  out  1  sticky; illegal code or illegal transition seen.

## Operation
- Code decode `{o1_in,o2_in,err_in}`: 000 = IDLE, 100 = S1, 010 = S2, 111 = ER. Any other value is an illegal code.
- Monitor FSM states M_IDLE, M_S1, M_S2, M_ER. Each cycle the state moves to the decoded phase of a legal code.
- Legal transitions (prev → cur):
  - IDLE → IDLE / S1 / ER
  - S1 → S1 / S2 / ER
  - S2 → S2 / IDLE / ER
  - ER → ER / IDLE
- Illegal transition (e.g. IDLE→S2, S1→IDLE, ER→S1, ER→S2): set `viol`. The state still follows the code (resynchronise). No count is taken on that cycle.
- Illegal code: set `viol`. The state holds and no count is taken.
- Pass event: legal S2 → IDLE. Increment `pass_cnt`, assert `pass_pulse`.
- Error event: legal entry into ER from IDLE, S1 or S2. Increment `err_cnt`. ER→ER is not an event.
- Counters saturate at 2^CNT_W−1 with no wrap. Sticky flags are unaffected by saturation.
- `err_alarm` sets when `err_cnt` (post-increment) equals `ERR_THRESH`. It stays set until `clr` or `rst`. Saturation never clears it.
- `clr`: both counters to 0, `err_alarm`=0, `viol`=0, `pass_pulse`=0. Monitor state still tracks the input code.
  - `clr` has priority over any event in the same cycle; that event is dropped.
  - A violation in the same cycle as `clr` is also dropped.
- `rst` (async, any time, including mid-pass): state M_IDLE; `pass_cnt`=0, `err_cnt`=0, `pass_pulse`=0, `err_alarm`=0, `viol`=0.
  - The first sampled code after reset is judged from M_IDLE. A code of ER counts an error; a code of S2 sets `viol`.

## Timing
- All outputs are registered.
- A code present during cycle c is evaluated at the rising edge ending c. Resulting counts and flags are visible in cycle c+1, i.e. one-cycle latency.
- `pass_pulse` is high for exactly one cycle per pass. Back-to-back passes yield separate pulses, minimum spacing 3 cycles given upstream legality.
- `err_alarm` rises in the same cycle `err_cnt` first shows `ERR_THRESH`.
- No input handshake: every cycle is a valid sample. Inputs must be synchronous to `clk`.

## Structure
- Shared package `fsm1_pkg` holds:
  - code constants CODE_IDLE=3'b000, CODE_S1=3'b100, CODE_S2=3'b010, CODE_ER=3'b111;
  - the monitor-state encoding.
- The controller and this monitor both import the package so the codes cannot diverge.
- Sub-module `sat_counter` (params W; ports `clk`, `rst`, `clr`, `inc`, `cnt`, `at_max`) is instantiated twice, for passes and errors.
- The legal-transition check, event detection and sticky flags live in the top module.

## Test plan
- Reset, then codes 000,100,010,000 on consecutive cycles → `pass_cnt`=1, one `pass_pulse` in the cycle after 000 is sampled, `viol`=0, `err_cnt`=0.
- Codes 000,100,111,111,000 repeated 4 times, `ERR_THRESH`=4 → `err_cnt`=4, `err_alarm` rises with the 4th count, ER→ER adds nothing, `pass_cnt`=0.
- Code 000 then 010 (IDLE→S2) → `viol`=1 next cycle, no count. Then 000 → legal, `viol` stays 1. Then `clr` pulse → `viol`=0.
- Code 110 (illegal) while in M_S1 → `viol`=1, state holds. A following 010 counts as legal S1→S2.
- `CNT_W`=2: 5 passes → `pass_cnt` holds at 3 and `pass_pulse` still fires 5 times. `clr` asserted in the same cycle as S2→IDLE → `pass_cnt`=0, no pulse.
- Assert `rst` while in M_S2 with `err_cnt`=2 → all outputs 0 immediately. Release with code 111 present → `err_cnt`=1 in the next cycle.
